triangle_cull: RTL and testbench

Culling stage between the projection unit and the triangle FIFO. It buffers projected screen-space triangles and discards those that are back-facing, degenerate, or entirely off-screen. It forwards the survivors into the triangle FIFO using that FIFO's write strobe and full flag. This keeps rasterization cycles for visible geometry only, and lets the control unit see when culling has drained.

---
 rtl/triangle_cull.sv | 236 +++++++++++++++++++++++
 tb/tb_triangle_cull.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_cull.sv
// triangle_cull: buffers projected screen-space triangles, discards back-facing, degenerate and
// fully off-screen ones, and forwards the survivors into the triangle FIFO.
// Optional feature macro: CULL_BACKFACE_EN. When defined, the SUB and MUL stages are built
// and the signed-area test is part of DECIDE. When undefined, only the off-screen tests apply.
module triangle_cull #(
  parameter int unsigned XMAX  = 640,
  parameter int unsigned YMAX  = 480,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 in_w,
  input  logic [2:0][1:0][9:0] triangle_in,
  output logic                 in_ready,
  input  logic                 fifo_full,
  output logic                 fifo_w,
  output logic [2:0][1:0][9:0] triangle_out,
  output logic                 idle,
  output logic                 drop,
  output logic [15:0]          cull_count,
  output logic [15:0]          pass_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  // One extra bit so screen extents up to 2047 compare correctly against 10-bit coordinates.
  localparam logic [10:0] XmaxC = 11'(XMAX);
  localparam logic [10:0] YmaxC = 11'(YMAX);

  typedef enum logic [2:0] {
    StIdle,
    StSub,
    StMul,
    StDecide,
    StWrite
  } state_e;

  // Input buffer
  logic [2:0][1:0][9:0] r_mem [DEPTH];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;
  logic                 r_in_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [CntW-1:0]      w_count_next;

  // FSM and working triangle
  state_e               r_state;
  logic [2:0][1:0][9:0] r_work;
  logic [15:0]          r_cull_count;
  logic [15:0]          r_pass_count;
  logic                 r_drop;
  logic                 w_cull;
  logic                 w_all_x_off;
  logic                 w_all_y_off;
  logic                 w_fifo_w;

  // Push only when ready was advertised; pop whenever the FSM is free and data is waiting.
  always_comb begin
    w_push = in_w && r_in_ready;
    w_pop  = (r_state == StIdle) && (r_count != '0);
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CntW'(1);
    end
  end

  // Triangle storage; contents need no reset since the pointers and count define validity.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= triangle_in;
    end
  end

  // Buffer pointers, occupancy and the registered ready flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < DepthC);
    end
  end

`ifdef CULL_BACKFACE_EN
  // Edge vectors and signed area of the working triangle
  logic signed [10:0] r_dx1;
  logic signed [10:0] r_dy1;
  logic signed [10:0] r_dx2;
  logic signed [10:0] r_dy2;
  logic signed [22:0] r_area;
  logic signed [10:0] w_dx1;
  logic signed [10:0] w_dy1;
  logic signed [10:0] w_dx2;
  logic signed [10:0] w_dy2;
  logic signed [21:0] w_p;
  logic signed [21:0] w_q;
  logic signed [22:0] w_area;

  // Zero-extend the unsigned pixel coordinates so the differences are exact 11-bit signed values.
  always_comb begin
    w_dx1  = $signed({1'b0, r_work[1][0]}) - $signed({1'b0, r_work[0][0]});
    w_dy1  = $signed({1'b0, r_work[1][1]}) - $signed({1'b0, r_work[0][1]});
    w_dx2  = $signed({1'b0, r_work[2][0]}) - $signed({1'b0, r_work[0][0]});
    w_dy2  = $signed({1'b0, r_work[2][1]}) - $signed({1'b0, r_work[0][1]});
    w_p    = 22'(r_dx1) * 22'(r_dy2);
    w_q    = 22'(r_dx2) * 22'(r_dy1);
    w_area = 23'(w_p) - 23'(w_q);
  end

  // SUB latches the edge vectors, MUL latches the signed area.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dx1  <= '0;
      r_dy1  <= '0;
      r_dx2  <= '0;
      r_dy2  <= '0;
      r_area <= '0;
    end else begin
      if (r_state == StSub) begin
        r_dx1 <= w_dx1;
        r_dy1 <= w_dy1;
        r_dx2 <= w_dx2;
        r_dy2 <= w_dy2;
      end
      if (r_state == StMul) begin
        r_area <= w_area;
      end
    end
  end
`endif

  // Cull decision: every vertex right of / below the screen, plus the area test when built.
  always_comb begin
    w_all_x_off = 1'b1;
    w_all_y_off = 1'b1;
    for (int v = 0; v < 3; v++) begin
      if ({1'b0, r_work[v][0]} < XmaxC) begin
        w_all_x_off = 1'b0;
      end
      if ({1'b0, r_work[v][1]} < YmaxC) begin
        w_all_y_off = 1'b0;
      end
    end
    w_cull = w_all_x_off || w_all_y_off;
`ifdef CULL_BACKFACE_EN
    // Non-positive area means clockwise on screen or degenerate.
    if (r_area <= 23'sd0) begin
      w_cull = 1'b1;
    end
`endif
  end

  // The write strobe follows fifo_full combinationally so a release is used in the same cycle.
  always_comb begin
    w_fifo_w = (r_state == StWrite) && !fifo_full;
  end

  // Main FSM with working register, saturating counters and sticky drop flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= StIdle;
      r_work       <= '0;
      r_cull_count <= '0;
      r_pass_count <= '0;
      r_drop       <= 1'b0;
    end else begin
      if (in_w && !r_in_ready) begin
        r_drop <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_work <= r_mem[r_rptr];
`ifdef CULL_BACKFACE_EN
            r_state <= StSub;
`else
            r_state <= StDecide;
`endif
          end
        end
`ifdef CULL_BACKFACE_EN
        StSub: begin
          r_state <= StMul;
        end
        StMul: begin
          r_state <= StDecide;
        end
`endif
        StDecide: begin
          if (w_cull) begin
            if (r_cull_count != 16'hFFFF) begin
              r_cull_count <= r_cull_count + 16'd1;
            end
            r_state <= StIdle;
          end else begin
            r_state <= StWrite;
          end
        end
        StWrite: begin
          if (w_fifo_w) begin
            if (r_pass_count != 16'hFFFF) begin
              r_pass_count <= r_pass_count + 16'd1;
            end
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign fifo_w       = w_fifo_w;
  assign triangle_out = r_work;
  assign idle         = (r_count == '0) && (r_state == StIdle);
  assign drop         = r_drop;
  assign cull_count   = r_cull_count;
  assign pass_count   = r_pass_count;

endmodule

// File: tb/tb_triangle_cull.sv
// tb_triangle_cull: directed bench for triangle_cull with hand-computed expectations.
// Follows CULL_BACKFACE_EN the same way the design does.
module tb_triangle_cull;

  typedef logic [2:0][1:0][9:0] tri_t;

`ifdef CULL_BACKFACE_EN
  localparam int Lat = 5;
  localparam bit BackfaceEn = 1'b1;
`else
  localparam int Lat = 3;
  localparam bit BackfaceEn = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        in_w;
  tri_t        triangle_in;
  logic        in_ready;
  logic        fifo_full;
  logic        fifo_w;
  tri_t        triangle_out;
  logic        idle;
  logic        drop;
  logic [15:0] cull_count;
  logic [15:0] pass_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pass = 0;
  int exp_cull = 0;

  triangle_cull #(
    .XMAX (640),
    .YMAX (480),
    .DEPTH(4)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .in_w        (in_w),
    .triangle_in (triangle_in),
    .in_ready    (in_ready),
    .fifo_full   (fifo_full),
    .fifo_w      (fifo_w),
    .triangle_out(triangle_out),
    .idle        (idle),
    .drop        (drop),
    .cull_count  (cull_count),
    .pass_count  (pass_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tri_t make_tri(input int x0, input int y0, input int x1, input int y1,
                                    input int x2, input int y2);
    tri_t t;
    t[0][0] = 10'(x0);
    t[0][1] = 10'(y0);
    t[1][0] = 10'(x1);
    t[1][1] = 10'(y1);
    t[2][0] = 10'(x2);
    t[2][1] = 10'(y2);
    return t;
  endfunction

  // Push one triangle into an idle, empty block and watch the 10 cycles that follow.
  // Called and returns at a falling edge.
  task automatic run_one(input string tag, input tri_t t, input bit exp_fw);
    int   pulses;
    int   first;
    int   k_idle;
    tri_t seen;
    pulses = 0;
    first  = -1;
    seen   = '0;
    k_idle = exp_fw ? Lat + 1 : Lat;
    in_w        = 1'b1;
    triangle_in = t;
    @(negedge Clk);
    in_w = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (fifo_w) begin
        pulses++;
        if (first < 0) first = k;
        seen = triangle_out;
      end
      if (k == 1) check_eq({tag, "_busy_n1"}, idle, 1'b0);
      if (k == k_idle - 1) check_eq({tag, "_idle_lo"}, idle, 1'b0);
      if (k == k_idle) check_eq({tag, "_idle_hi"}, idle, 1'b1);
      @(negedge Clk);
    end
    check_eq({tag, "_pulses"}, pulses, exp_fw ? 1 : 0);
    if (exp_fw) begin
      check_eq({tag, "_latency"}, first, Lat);
      check_eq({tag, "_tri_out"}, seen, t);
      exp_pass++;
    end else begin
      exp_cull++;
    end
    check_eq({tag, "_pass_cnt"}, pass_count, exp_pass);
    check_eq({tag, "_cull_cnt"}, cull_count, exp_cull);
  endtask

  initial begin
    tri_t bp [6];
    int   pulses;
    Reset_n     = 1'b0;
    in_w        = 1'b0;
    fifo_full   = 1'b0;
    triangle_in = '0;
    repeat (2) @(negedge Clk);

    // Reset state
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_idle", idle, 1'b1);
    check_eq("rst_fifo_w", fifo_w, 1'b0);
    check_eq("rst_drop", drop, 1'b0);
    check_eq("rst_cull", cull_count, 16'h0);
    check_eq("rst_pass", pass_count, 16'h0);
    check_eq("rst_tri_out", triangle_out, '0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Counter-clockwise (area 100) passes; clockwise (area -100) passes only without the area test
    run_one("ccw", make_tri(0, 0, 10, 0, 0, 10), 1'b1);
    run_one("cw", make_tri(0, 0, 0, 10, 10, 0), !BackfaceEn);
    // Counter-clockwise but all x >= 640
    run_one("offx", make_tri(700, 0, 800, 5, 650, 40), 1'b0);
    // All y >= 480
    run_one("offy", make_tri(0, 500, 10, 500, 0, 510), 1'b0);
    // Boundary: one vertex at x = 639 keeps it on-screen
    run_one("edgex", make_tri(639, 0, 700, 0, 639, 10), 1'b1);

    // Back-pressure: six consecutive pushes with the FIFO full
    for (int i = 0; i < 6; i++) bp[i] = make_tri(i, 0, i + 10, 0, i, 10);
    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("bp_in_ready_%0d", i), in_ready, (i < 5) ? 1'b1 : 1'b0);
      in_w        = 1'b1;
      triangle_in = bp[i];
      @(negedge Clk);
    end
    in_w = 1'b0;
    check_eq("bp_drop", drop, 1'b1);
    repeat (8) @(negedge Clk);
    check_eq("bp_hold_tri_a", triangle_out, bp[0]);
    check_eq("bp_hold_fw", fifo_w, 1'b0);
    @(negedge Clk);
    check_eq("bp_hold_tri_b", triangle_out, bp[0]);
    check_eq("bp_hold_ready", in_ready, 1'b0);
    fifo_full = 1'b0;
    #1;
    check_eq("bp_release_fw", fifo_w, 1'b1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (fifo_w) begin
        if (pulses < 5) check_eq($sformatf("bp_order_%0d", pulses), triangle_out, bp[pulses]);
        pulses++;
      end
      @(negedge Clk);
      #1;
    end
    exp_pass += 5;
    check_eq("bp_pulses", pulses, 5);
    check_eq("bp_pass_cnt", pass_count, exp_pass);
    check_eq("bp_drop_sticky", drop, 1'b1);
    check_eq("bp_idle_end", idle, 1'b1);
    check_eq("bp_ready_end", in_ready, 1'b1);

    // Reset mid-flight: three pushes leave one in work and two buffered
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      in_w        = 1'b1;
      triangle_in = bp[i];
      @(negedge Clk);
    end
    in_w    = 1'b0;
    Reset_n = 1'b0;
    #1;
    check_eq("mid_rst_fw", fifo_w, 1'b0);
    check_eq("mid_rst_ready", in_ready, 1'b1);
    check_eq("mid_rst_idle", idle, 1'b1);
    check_eq("mid_rst_drop", drop, 1'b0);
    check_eq("mid_rst_pass", pass_count, 16'h0);
    check_eq("mid_rst_cull", cull_count, 16'h0);
    check_eq("mid_rst_tri", triangle_out, '0);
    exp_pass = 0;
    exp_cull = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (fifo_w) pulses++;
    end
    check_eq("post_rst_pulses", pulses, 0);
    check_eq("post_rst_idle", idle, 1'b1);

    // Saturation of the cull counter
    force dut.r_cull_count = 16'hFFFE;
    @(negedge Clk);
    release dut.r_cull_count;
    check_eq("sat_preload", cull_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      in_w        = 1'b1;
      triangle_in = make_tri(700, 0, 800, 5, 650, 40);
      @(negedge Clk);
      in_w = 1'b0;
      repeat (Lat + 2) @(negedge Clk);
      check_eq($sformatf("sat_cull_%0d", i), cull_count, 16'hFFFF);
    end
    check_eq("sat_pass", pass_count, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
